// File: rtl/xgmii_multilane_frame_gen.sv
// Multi-lane XGMII frame generator: START, preamble, SFD, payload, TERMINATE, then inter-packet gap.
// Define XGMII_FRAME_GEN_STATS_EN to add saturating o_frame_cnt / o_abort_cnt outputs.
module xgmii_multilane_frame_gen #(
  parameter int unsigned LANES          = 8,
  parameter int unsigned MIN_LEN        = 46,
  parameter int unsigned MAX_LEN        = 1500,
  parameter int unsigned IPG_CYCLES     = 1,
  parameter logic [7:0]  IDLE_CODE      = 8'h07,
  parameter logic [7:0]  START_CODE     = 8'hFB,
  parameter logic [7:0]  PREAMBLE_CODE  = 8'h55,
  parameter logic [7:0]  SFD_CODE       = 8'hD5,
  parameter logic [7:0]  TERMINATE_CODE = 8'hFD,
  parameter logic [7:0]  ERROR_CODE     = 8'hFE,
  parameter logic [7:0]  DATA_PATTERN   = 8'hAA
) (
  input  logic                         tx_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [$clog2(MAX_LEN+1)-1:0] i_len,
  input  logic [1:0]                   i_mode,
  input  logic                         i_abort,
  output logic [8*LANES-1:0]           o_tx_data,
  output logic [LANES-1:0]             o_tx_ctrl,
  output logic                         o_ready,
  output logic                         o_done
`ifdef XGMII_FRAME_GEN_STATS_EN
  ,
  output logic [31:0]                  o_frame_cnt,
  output logic [15:0]                  o_abort_cnt
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN+1);
  localparam int unsigned POS_W = $clog2(9+MAX_LEN+LANES+1);
  localparam int unsigned GAP_W = $clog2(IPG_CYCLES+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_IPG   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, len_clamped, cur_len;
  logic [1:0]         mode_q, mode_d, cur_mode;
  logic [POS_W-1:0]   pos_q, pos_d, cur_pos, term_pos;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [8*LANES-1:0] frame_data, data_d;
  logic [LANES-1:0]   frame_ctrl, ctrl_d;
  logic               frame_term, done_d, err_d, ready_d;

  always_comb begin
    len_clamped = i_len;
    if (i_len < LEN_W'(MIN_LEN))
      len_clamped = LEN_W'(MIN_LEN);
    else if (i_len > LEN_W'(MAX_LEN))
      len_clamped = LEN_W'(MAX_LEN);
  end

  // In IDLE the word is built from the live request so START appears right after the accepting edge.
  always_comb begin
    cur_len    = (state_q == S_IDLE) ? len_clamped : len_q;
    cur_mode   = (state_q == S_IDLE) ? i_mode : mode_q;
    cur_pos    = (state_q == S_IDLE) ? '0 : pos_q;
    term_pos   = POS_W'(cur_len) + POS_W'(8);
    frame_term = (term_pos >= cur_pos) && (term_pos < cur_pos + POS_W'(LANES));
    frame_data = '0;
    frame_ctrl = '0;
    for (int unsigned n = 0; n < LANES; n++) begin
      logic [POS_W-1:0] p;
      logic [7:0]       kb;
      p  = cur_pos + POS_W'(n);
      kb = p[7:0] - 8'd8;
      if (p == '0) begin
        frame_data[8*n +: 8] = START_CODE;
        frame_ctrl[n]        = 1'b1;
      end else if (p < POS_W'(7)) begin
        frame_data[8*n +: 8] = PREAMBLE_CODE;
      end else if (p == POS_W'(7)) begin
        frame_data[8*n +: 8] = SFD_CODE;
      end else if (p < term_pos) begin
        case (cur_mode)
          2'd1:    frame_data[8*n +: 8] = DATA_PATTERN;
          2'd2:    frame_data[8*n +: 8] = 8'h00;
          default: frame_data[8*n +: 8] = kb;
        endcase
      end else if (p == term_pos) begin
        frame_data[8*n +: 8] = TERMINATE_CODE;
        frame_ctrl[n]        = 1'b1;
      end else begin
        frame_data[8*n +: 8] = IDLE_CODE;
        frame_ctrl[n]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    gap_d   = gap_q;
    data_d  = {LANES{IDLE_CODE}};
    ctrl_d  = '1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE, S_FRAME: begin
        if (state_q == S_FRAME && i_abort) begin
          data_d  = {LANES{ERROR_CODE}};
          err_d   = 1'b1;
          state_d = S_IPG;
          gap_d   = GAP_W'(IPG_CYCLES);
        end else if (state_q == S_FRAME || i_start) begin
          data_d  = frame_data;
          ctrl_d  = frame_ctrl;
          len_d   = cur_len;
          mode_d  = cur_mode;
          pos_d   = cur_pos + POS_W'(LANES);
          state_d = S_FRAME;
          if (frame_term) begin
            done_d  = 1'b1;
            state_d = S_IPG;
            gap_d   = GAP_W'(IPG_CYCLES);
          end
        end
      end
      S_IPG: begin
        if (gap_q <= GAP_W'(1))
          state_d = S_IDLE;
        else
          gap_d = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge tx_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      pos_q     <= '0;
      gap_q     <= '0;
      o_tx_data <= {LANES{IDLE_CODE}};
      o_tx_ctrl <= '1;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      gap_q     <= gap_d;
      o_tx_data <= data_d;
      o_tx_ctrl <= ctrl_d;
      o_ready   <= ready_d;
      o_done    <= done_d;
    end
  end

`ifdef XGMII_FRAME_GEN_STATS_EN
  always_ff @(posedge tx_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_abort_cnt <= '0;
    end else begin
      if (done_d && o_frame_cnt != '1)
        o_frame_cnt <= o_frame_cnt + 32'd1;
      if (err_d && o_abort_cnt != '1)
        o_abort_cnt <= o_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_multilane_frame_gen.sv
// Scoreboard bench for xgmii_multilane_frame_gen (LANES=8): IPG_CYCLES=1 instance plus an IPG_CYCLES=3 instance.
module tb_xgmii_multilane_frame_gen;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        done;
    logic        ready;
  } exp_t;

  logic        tx_clk = 1'b0;
  logic        i_rst;
  logic        i_start, i_abort;
  logic [10:0] i_len;
  logic [1:0]  i_mode;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_ready, o_done;

  logic        i3_start;
  logic [63:0] o3_tx_data;
  logic [7:0]  o3_tx_ctrl;
  logic        o3_ready, o3_done;

`ifdef XGMII_FRAME_GEN_STATS_EN
  logic [31:0] o_frame_cnt, o3_frame_cnt;
  logic [15:0] o_abort_cnt, o3_abort_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_frames = 0;
  int exp_aborts = 0;
  exp_t q[$];
  exp_t q3[$];

  always #5 tx_clk = ~tx_clk;

  xgmii_multilane_frame_gen #(.LANES(8), .IPG_CYCLES(1)) dut (
    .tx_clk(tx_clk), .i_rst(i_rst), .i_start(i_start), .i_len(i_len), .i_mode(i_mode),
    .i_abort(i_abort), .o_tx_data(o_tx_data), .o_tx_ctrl(o_tx_ctrl), .o_ready(o_ready),
    .o_done(o_done)
`ifdef XGMII_FRAME_GEN_STATS_EN
    , .o_frame_cnt(o_frame_cnt), .o_abort_cnt(o_abort_cnt)
`endif
  );

  xgmii_multilane_frame_gen #(.LANES(8), .IPG_CYCLES(3)) dut3 (
    .tx_clk(tx_clk), .i_rst(i_rst), .i_start(i3_start), .i_len(11'd46), .i_mode(2'd1),
    .i_abort(1'b0), .o_tx_data(o3_tx_data), .o_tx_ctrl(o3_tx_ctrl), .o_ready(o3_ready),
    .o_done(o3_done)
`ifdef XGMII_FRAME_GEN_STATS_EN
    , .o_frame_cnt(o3_frame_cnt), .o_abort_cnt(o3_abort_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_word(input logic rdy);
    exp_t e;
    e.data  = {8{8'h07}};
    e.ctrl  = 8'hFF;
    e.done  = 1'b0;
    e.ready = rdy;
    return e;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len);
    if (len < 46) return 46;
    if (len > 1500) return 1500;
    return len;
  endfunction

  // Reference byte map for word j of a frame with clamped length lc.
  function automatic exp_t frame_word(input int unsigned lc, input logic [1:0] mode, input int unsigned j);
    exp_t e;
    e.done  = 1'b0;
    e.ready = 1'b0;
    e.ctrl  = 8'h00;
    e.data  = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      int unsigned p;
      logic [7:0] b;
      logic c;
      p = j * 8 + n;
      c = 1'b0;
      if (p == 0) begin b = 8'hFB; c = 1'b1; end
      else if (p <= 6) b = 8'h55;
      else if (p == 7) b = 8'hD5;
      else if (p < 8 + lc) begin
        if (mode == 2'd1) b = 8'hAA;
        else if (mode == 2'd2) b = 8'h00;
        else b = 8'((p - 8) % 256);
      end
      else if (p == 8 + lc) begin b = 8'hFD; c = 1'b1; e.done = 1'b1; end
      else begin b = 8'h07; c = 1'b1; end
      e.data[8*n +: 8] = b;
      e.ctrl[n] = c;
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge tx_clk); #2;
      e = (q.size() > 0) ? q.pop_front() : idle_word(1'b1);
      check("data", o_tx_data, e.data);
      check("ctrl", 64'(o_tx_ctrl), 64'(e.ctrl));
      check("done", 64'(o_done), 64'(e.done));
      check("ready", 64'(o_ready), 64'(e.ready));
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge tx_clk); #2;
      e = (q3.size() > 0) ? q3.pop_front() : idle_word(1'b1);
      check("ipg3_data", o3_tx_data, e.data);
      check("ipg3_ctrl", 64'(o3_tx_ctrl), 64'(e.ctrl));
      check("ipg3_done", 64'(o3_done), 64'(e.done));
      check("ipg3_ready", 64'(o3_ready), 64'(e.ready));
    end
  end

  task automatic drain(input string tag);
    for (int c = 0; c < 2000 && (q.size() > 0 || q3.size() > 0); c++) @(negedge tx_clk);
    check(tag, 64'(q.size() + q3.size()), 64'd0);
    repeat (2) @(negedge tx_clk);
  endtask

  task automatic check_stats(input string tag);
`ifdef XGMII_FRAME_GEN_STATS_EN
    check({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_frames));
    check({tag, "_abort_cnt"}, 64'(o_abort_cnt), 64'(exp_aborts));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // abort_word: -1 none, 0 abort together with start, j>0 replaces word j with the error word.
  task automatic send_frame(input int unsigned len, input logic [1:0] mode,
                            input int abort_word, input int abort_hold);
    int unsigned lc, nw;
    exp_t e;
    lc = clamp_len(len);
    nw = (9 + lc + 7) / 8;
    @(negedge tx_clk);
    i_start = 1'b1;
    i_len   = 11'(len);
    i_mode  = mode;
    if (abort_word == 0) i_abort = 1'b1;
    for (int unsigned j = 0; j < nw; j++) begin
      if (abort_word > 0 && j == unsigned'(abort_word)) begin
        e.data = {8{8'hFE}}; e.ctrl = 8'hFF; e.done = 1'b0; e.ready = 1'b0;
        q.push_back(e);
        exp_aborts++;
        break;
      end
      q.push_back(frame_word(lc, mode, j));
      if (j == nw - 1) exp_frames++;
    end
    q.push_back(idle_word(1'b1));
    @(negedge tx_clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    i_len   = '0;
    i_mode  = 2'd0;
    if (abort_word > 0) begin
      repeat (abort_word - 1) @(negedge tx_clk);
      i_abort = 1'b1;
      repeat (abort_hold) @(negedge tx_clk);
      i_abort = 1'b0;
    end
    drain("drain");
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_len = '0; i_mode = '0; i3_start = 1'b0;
    #1;
    check("rst_data", o_tx_data, {8{8'h07}});
    check("rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_done", 64'(o_done), 64'd0);
    repeat (2) @(negedge tx_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge tx_clk);

    send_frame(46, 2'd1, 4, 2);       // abort in frame cycle 3, held into IPG
    check_stats("abort");
    send_frame(46, 2'd1, -1, 0);
    send_frame(10, 2'd1, -1, 0);
    send_frame(300, 2'd0, -1, 0);
    send_frame(2000, 2'd2, -1, 0);
    send_frame(60, 2'd3, -1, 0);
    send_frame(46, 2'd1, 6, 1);       // abort on the terminate edge
    send_frame(46, 2'd1, 0, 0);       // start and abort together in IDLE
    @(negedge tx_clk); i_abort = 1'b1; @(negedge tx_clk); i_abort = 1'b0;
    repeat (2) @(negedge tx_clk);
    check_stats("mid");

    // Reset in frame cycle 2: frame discarded, outputs idle at once.
    @(negedge tx_clk);
    i_start = 1'b1; i_len = 11'd100; i_mode = 2'd0;
    for (int unsigned j = 0; j < 3; j++) q.push_back(frame_word(100, 2'd0, j));
    @(negedge tx_clk);
    i_start = 1'b0;
    repeat (2) @(negedge tx_clk);
    i_rst = 1'b1;
    exp_frames = 0;
    exp_aborts = 0;
    #1;
    check("rst_mid_data", o_tx_data, {8{8'h07}});
    check("rst_mid_ctrl", 64'(o_tx_ctrl), 64'hFF);
    check("rst_mid_ready", 64'(o_ready), 64'd1);
    check("rst_mid_done", 64'(o_done), 64'd0);
    check("rst_mid_q", 64'(q.size()), 64'd0);
    check_stats("rst_mid");
    repeat (2) @(negedge tx_clk);
    i_rst = 1'b0;
    send_frame(46, 2'd1, -1, 0);
    check_stats("after_rst");

    // IPG_CYCLES=3 instance with i_start held high across three frames.
    @(negedge tx_clk);
    i3_start = 1'b1;
    for (int unsigned f = 0; f < 3; f++) begin
      for (int unsigned j = 0; j < 7; j++) q3.push_back(frame_word(46, 2'd1, j));
      q3.push_back(idle_word(1'b0));
      q3.push_back(idle_word(1'b0));
      q3.push_back(idle_word(1'b1));
    end
    repeat (25) @(negedge tx_clk);
    i3_start = 1'b0;
    drain("drain_ipg3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xgmii_multilane_frame_gen.md
# xgmii_multilane_frame_gen

Parametrised multi-lane successor to the team's byte-wide MII frame generator. Emits complete Ethernet frames on an XGMII-style bus of `LANES` byte lanes per `tx_clk`: START, preamble, SFD, payload of run-time length, TERMINATE, then a programmable inter-packet gap. It adds run-time length, payload modes, mid-frame abort with error code, and a ready/done handshake. It sits in front of the PCS encoder as the traffic source for link bring-up and loopback tests.

## Interface
- `LANES`, 8: byte lanes per cycle. Legal values are 4, 8 and 16.
- `MIN_LEN`, 46: minimum payload bytes; shorter requests are clamped up to this.
- `MAX_LEN`, 1500: maximum payload bytes; longer requests are clamped down to this.
- `IPG_CYCLES`, 1: full idle cycles after the terminate word. Must be at least 1.
- `IDLE_CODE` 8'h07, `START_CODE` 8'hFB, `PREAMBLE_CODE` 8'h55, `SFD_CODE` 8'hD5, `TERMINATE_CODE` 8'hFD, `ERROR_CODE` 8'hFE, `DATA_PATTERN` 8'hAA: the codes used on the bus.
- `tx_clk  in  1`: transmit clock.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `i_start  in  1`: frame request. Sampled only while `o_ready`=1.
- `i_len  in  $clog2(MAX_LEN+1)`: payload length. Latched on an accepted start.
- `i_mode  in  2`: payload mode. Latched on an accepted start.
- `i_abort  in  1`: abort the frame in progress.
- `o_tx_data  out  8*LANES`: lane n occupies bits [8n+7:8n]. Lane 0 carries the earliest byte.
- `o_tx_ctrl  out  LANES`: bit n=1 means lane n carries a control character.
- `o_ready  out  1`: generator is idle and will accept `i_start`.
- `o_done  out  1`: one-cycle pulse with the terminate word.

## Operation
- FSM states: IDLE, FRAME, IPG. Outputs are registered from next-state logic.
- IDLE:
  - Bus shows all lanes `IDLE_CODE`, ctrl all ones.
  - `i_start`=1 latches len_q = clamp(i_len), latches mode_q, clears byte position pos, and goes to FRAME.
- FRAME byte map, with frame position p = pos + lane:
  - p=0: START (ctrl).
  - p=1..6: PREAMBLE (data).
  - p=7: SFD (data).
  - p=8..7+len_q: payload byte k=p-8 (data).
  - p=8+len_q: TERMINATE (ctrl).
  - p>8+len_q: IDLE (ctrl).
  - pos advances by LANES each cycle. The pos width must hold 9+MAX_LEN+LANES without wrap.
- Payload by mode_q:
  - 0: k[7:0], incrementing and wrapping at 256.
  - 1: `DATA_PATTERN`.
  - 2: 8'h00.
  - 3: same as 0.
- Exit from FRAME: the cycle whose lanes contain p=8+len_q is the terminate cycle. It pulses `o_done`, loads the gap counter with IPG_CYCLES, and goes to IPG.
- IPG: emits all-idle words for IPG_CYCLES cycles, then goes to IDLE. `i_start` is ignored in IPG.
- Abort: `i_abort`=1 sampled in FRAME replaces the next word with all lanes `ERROR_CODE`, ctrl all ones, then goes to IPG. No `o_done` pulse.
- Simultaneous events:
  - Abort on the edge that would produce the terminate word: abort wins.
  - `i_abort` in IDLE or IPG: ignored.
  - `i_start` and `i_abort` together in IDLE: start wins.
- Reset, including mid-frame: the frame is discarded with no terminate or error word.
  - State returns to IDLE.
  - `o_tx_data` = all lanes `IDLE_CODE`; `o_tx_ctrl` all ones.
  - `o_ready`=1 and `o_done`=0.
  - Stats counters, when compiled in, are zeroed.

## Timing
- Accepted `i_start` at edge k produces the START word on the outputs right after edge k. `o_ready` falls at the same edge.
- Frame duration is ceil((9+len_q)/LANES) cycles, START through terminate.
- `o_ready` rises IPG_CYCLES cycles after the terminate or error cycle.
- The earliest back-to-back start is sampled at the first edge where `o_ready`=1.
- `i_abort` takes effect on the very next word.

## Configuration
- `XGMII_FRAME_GEN_STATS_EN` defined adds two outputs:
  - `o_frame_cnt`, 32 bits: increments on each `o_done`.
  - `o_abort_cnt`, 16 bits: increments on each error word.
  - Both saturate at their maximum value and reset to 0.
- Without the macro, neither port nor either counter exists, and all other behaviour is identical.

## Test plan
- LANES=8, len=46, mode 1, one start produces 7 frame cycles:
  - Word 0 is FB 55 55 55 55 55 55 D5 with ctrl 8'h01.
  - Words 1-5 are all AA with ctrl 8'h00.
  - Word 6 has lanes 0-5 AA, lane 6 FD, lane 7 07, ctrl 8'hC0, with `o_done`=1.
  - One idle cycle follows, then `o_ready`=1.
- len=10 is clamped to 46, giving the same 7-cycle frame. len=2000 is clamped to 1500, giving a 189-cycle frame.
- Mode 0 with len=300: payload byte k equals k mod 256, so byte 256 = 8'h00 and byte 299 = 8'h2B.
- `i_abort` pulsed in frame cycle 3:
  - Cycle 4 is all FE with ctrl 8'hFF.
  - IPG follows and `o_done` never pulses.
  - With stats enabled, `o_abort_cnt`=1 and `o_frame_cnt`=0.
- `i_rst` asserted in frame cycle 2:
  - Outputs go immediately to all 07 with ctrl 8'hFF and `o_ready`=1.
  - After release, a new start gives a correct full frame.
- `i_start` held high continuously with IPG_CYCLES=3: frames are separated by exactly 3 all-idle words, and starts during IPG are ignored.
